seg7_scan_ctrl: RTL

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_scan_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pkg : shared types and constants for the 7-segment scan controller
// Rev 1.0
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } seg7_scan_state_t;

    localparam logic [3:0] SEG7_BLANK_CODE = 4'hF;

    function automatic logic bcd_is_zero(input logic [3:0] d);
        return (d == 4'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_ctrl : N-digit multiplexed 7-segment scan controller with
// frame-synchronous shadow update. Option: LEADING_ZERO_BLANK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    LOAD,
    output logic [3:0]              DIGIT_D,
    output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
    output logic                    FRAME_TICK
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);

    logic [1:0]              rst_sync_q;
    logic                    rst_n_int;
    seg7_scan_state_t        state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    slot_end, frame_wrap, enter_scan;
    logic [3:0]              cur_digit;

    // Asynchronous assertion, release aligned to CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    assign slot_end   = (state_q == ST_SHOW) && (div_q == DIV_LAST);
    assign frame_wrap = EN && slot_end && (idx_q == IDX_LAST);
    assign enter_scan = EN && (state_q == ST_IDLE);

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            idx_q      <= '0;
            pending_q  <= '0;
            shadow_q   <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_BLANK;
                ST_BLANK: if (div_q == BLANK_LAST) state_d = ST_SHOW;
                ST_SHOW:  if (slot_end) state_d = ST_BLANK;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        div_d      = div_q + DIV_W'(1);
        idx_d      = idx_q;
        pending_d  = pending_q;
        shadow_d   = shadow_q;
        pend_vld_d = pend_vld_q;
        if (!EN || (state_q == ST_IDLE)) begin
            div_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        // Shadow only moves on a frame boundary so a frame is never torn.
        if ((frame_wrap || enter_scan) && pend_vld_q) begin
            shadow_d   = pending_q;
            pend_vld_d = 1'b0;
        end
        if (LOAD) begin
            pending_d  = VALUE;
            pend_vld_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:1] lead_zero;

    always_comb begin
        lead_zero[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero[i] = lead_zero[i+1] && bcd_is_zero(shadow_q[4*i +: 4]);
        end
    end
`endif

    always_comb begin
        cur_digit = SEG7_BLANK_CODE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = shadow_q[4*i +: 4];
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if ((idx_q == IDX_W'(i)) && lead_zero[i]) cur_digit = SEG7_BLANK_CODE;
        end
`endif
    end

    always_comb begin
        DIGIT_D    = (state_q == ST_IDLE) ? SEG7_BLANK_CODE : cur_digit;
        DIGIT_SEL  = '1;
        FRAME_TICK = frame_wrap;
        if (state_q == ST_SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) DIGIT_SEL[i] = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
